// File: rtl/game_state_manager.sv
// Game flow controller: menu navigation, timed dodge phases, and the
// game-over/win/restart sequencing for the bullet-dodge game.
//
// state    | meaning
// ---------+--------------------------------------------------------
// MENU     | player picks FIGHT / ACT / MERCY with LEFT/RIGHT/ENTER
// DODGE    | timed phase; frames_left counts down on frame_tick
// GAMEOVER | player HP reached 0; ENTER restarts
// WIN      | enemy defeated or spared; ENTER restarts
module game_state_manager #(
   parameter int DODGE_FRAMES  = 600,
   parameter int ENEMY_HP_INIT = 4,
   parameter int SPARE_ACTS    = 2
) (
   input  logic        clk,
   input  logic        btnC,
   input  logic        frame_tick,
   input  logic [15:0] keycode,
   input  logic [1:0]  hp,
   output logic [1:0]  state,
   output logic [1:0]  cursor,
   output logic [2:0]  enemy_hp,
   output logic [9:0]  frames_left,
   output logic [7:0]  round,
   output logic        phase_start,
   output logic        player_reset
);

   typedef enum logic [1:0] {
      ST_MENU     = 2'b00,
      ST_DODGE    = 2'b01,
      ST_GAMEOVER = 2'b10,
      ST_WIN      = 2'b11
   } state_t;

   localparam logic [7:0] KEY_BREAK = 8'hF0;
   localparam logic [7:0] KEY_LEFT  = 8'h6B;
   localparam logic [7:0] KEY_RIGHT = 8'h74;
   localparam logic [7:0] KEY_ENTER = 8'h5A;

   localparam logic [9:0] DODGE_LOAD = 10'(DODGE_FRAMES);
   localparam logic [2:0] HP_LOAD    = 3'(ENEMY_HP_INIT);
   localparam logic [2:0] SPARE_MIN  = 3'(SPARE_ACTS);

   state_t      state_q, state_d;
   logic [1:0]  cursor_q, cursor_d;
   logic [2:0]  enemy_hp_q, enemy_hp_d;
   logic [9:0]  frames_left_q, frames_left_d;
   logic [7:0]  round_q, round_d;
   logic [2:0]  act_q, act_d;
   logic        phase_start_q, phase_start_d;
   logic        player_reset_q, player_reset_d;
   logic [15:0] keycode_q, keycode_d;

   logic       key_evt, key_left, key_right, key_enter;
   logic [2:0] hp_dec;

   // Only a changed make code counts; anything involving F0 is a break sequence.
   always_comb begin
      key_evt   = (keycode != keycode_q) && (keycode[15:8] != KEY_BREAK)
                  && (keycode[7:0] != KEY_BREAK);
      key_left  = key_evt && (keycode[7:0] == KEY_LEFT);
      key_right = key_evt && (keycode[7:0] == KEY_RIGHT);
      key_enter = key_evt && (keycode[7:0] == KEY_ENTER);
      hp_dec    = (enemy_hp_q == 3'd0) ? 3'd0 : enemy_hp_q - 3'd1;
   end

   always_comb begin
      state_d        = state_q;
      cursor_d       = cursor_q;
      enemy_hp_d     = enemy_hp_q;
      frames_left_d  = frames_left_q;
      round_d        = round_q;
      act_d          = act_q;
      phase_start_d  = 1'b0;
      player_reset_d = 1'b0;
      keycode_d      = keycode;

      unique case (state_q)
         ST_MENU: begin
            if (key_left && cursor_q != 2'd0) begin
               cursor_d = cursor_q - 2'd1;
            end else if (key_right && cursor_q < 2'd2) begin
               cursor_d = cursor_q + 2'd1;
            end else if (key_enter) begin
               // Default outcome of any menu action is a new dodge phase.
               state_d       = ST_DODGE;
               frames_left_d = DODGE_LOAD;
               phase_start_d = 1'b1;
               case (cursor_q)
                  2'd0: begin
                     enemy_hp_d = hp_dec;
                     if (hp_dec == 3'd0) begin
                        state_d       = ST_WIN;
                        frames_left_d = 10'd0;
                        phase_start_d = 1'b0;
                     end
                  end
                  2'd1: begin
                     if (act_q != 3'd7) act_d = act_q + 3'd1;
                  end
                  2'd2: begin
                     if (act_q >= SPARE_MIN) begin
                        state_d       = ST_WIN;
                        frames_left_d = 10'd0;
                        phase_start_d = 1'b0;
                     end
                  end
                  default: begin
                     state_d       = ST_MENU;
                     frames_left_d = 10'd0;
                     phase_start_d = 1'b0;
                  end
               endcase
            end
         end
         ST_DODGE: begin
            // Death wins over expiry so the round is not credited.
            if (hp == 2'd0) begin
               state_d       = ST_GAMEOVER;
               frames_left_d = 10'd0;
            end else if (frame_tick) begin
               if (frames_left_q <= 10'd1) begin
                  frames_left_d = 10'd0;
                  round_d       = round_q + 8'd1;
                  state_d       = ST_MENU;
                  cursor_d      = 2'd0;
               end else begin
                  frames_left_d = frames_left_q - 10'd1;
               end
            end
         end
         ST_GAMEOVER, ST_WIN: begin
            if (key_enter) begin
               state_d        = ST_MENU;
               cursor_d       = 2'd0;
               round_d        = 8'd0;
               act_d          = 3'd0;
               enemy_hp_d     = HP_LOAD;
               player_reset_d = 1'b1;
            end
         end
         default: state_d = ST_MENU;
      endcase
   end

   always_ff @(posedge clk or posedge btnC) begin
      if (btnC) begin
         state_q        <= ST_MENU;
         cursor_q       <= 2'd0;
         enemy_hp_q     <= HP_LOAD;
         frames_left_q  <= 10'd0;
         round_q        <= 8'd0;
         act_q          <= 3'd0;
         phase_start_q  <= 1'b0;
         player_reset_q <= 1'b0;
         keycode_q      <= 16'd0;
      end else begin
         state_q        <= state_d;
         cursor_q       <= cursor_d;
         enemy_hp_q     <= enemy_hp_d;
         frames_left_q  <= frames_left_d;
         round_q        <= round_d;
         act_q          <= act_d;
         phase_start_q  <= phase_start_d;
         player_reset_q <= player_reset_d;
         keycode_q      <= keycode_d;
      end
   end

   assign state        = state_q;
   assign cursor       = cursor_q;
   assign enemy_hp     = enemy_hp_q;
   assign frames_left  = frames_left_q;
   assign round        = round_q;
   assign phase_start  = phase_start_q;
   assign player_reset = player_reset_q;

endmodule

// File: tb/tb_game_state_manager.sv
// Directed bench for game_state_manager: menu navigation, dodge timing,
// game-over priority, mercy/act win path, restart and async reset.
module tb_game_state_manager;

   logic        clk = 1'b0;
   logic        btnC;
   logic        frame_tick;
   logic [15:0] keycode;
   logic [1:0]  hp;
   logic [1:0]  state;
   logic [1:0]  cursor;
   logic [2:0]  enemy_hp;
   logic [9:0]  frames_left;
   logic [7:0]  round;
   logic        phase_start;
   logic        player_reset;

   int n_vec = 0;
   int n_err = 0;

   game_state_manager dut (
      .clk          (clk),
      .btnC         (btnC),
      .frame_tick   (frame_tick),
      .keycode      (keycode),
      .hp           (hp),
      .state        (state),
      .cursor       (cursor),
      .enemy_hp     (enemy_hp),
      .frames_left  (frames_left),
      .round        (round),
      .phase_start  (phase_start),
      .player_reset (player_reset)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   // Neutral code first so the make code always registers as a change.
   task automatic press(input logic [7:0] code);
      keycode = 16'h0000;
      cyc();
      keycode = {8'h00, code};
      cyc();
   endtask

   task automatic ticks(input int n);
      for (int i = 0; i < n; i++) begin
         frame_tick = 1'b1;
         cyc();
      end
      frame_tick = 1'b0;
   endtask

   initial begin
      btnC = 1'b1; frame_tick = 1'b0; keycode = 16'h0000; hp = 2'd3;
      #2;
      chk("rst_state", state, 0);
      chk("rst_cursor", cursor, 0);
      chk("rst_ehp", enemy_hp, 4);
      chk("rst_frames", frames_left, 0);
      chk("rst_round", round, 0);
      chk("rst_ps", phase_start, 0);
      chk("rst_pr", player_reset, 0);
      cyc(); cyc();
      btnC = 1'b0;
      cyc();

      // cursor navigation with saturation
      press(8'h74); chk("cur_r1", cursor, 1);
      press(8'h74); chk("cur_r2", cursor, 2);
      press(8'h74); chk("cur_r3_sat", cursor, 2);
      press(8'h6B); chk("cur_l1", cursor, 1);
      press(8'h6B); chk("cur_l0", cursor, 0);
      press(8'h6B); chk("cur_l_sat", cursor, 0);
      press(8'h12); chk("cur_other", cursor, 0);
      chk("menu_other", state, 0);

      // FIGHT -> dodge phase
      press(8'h5A);
      chk("fight_state", state, 1);
      chk("fight_ehp", enemy_hp, 3);
      chk("fight_ps", phase_start, 1);
      chk("fight_frames", frames_left, 600);
      cyc();
      chk("fight_ps_once", phase_start, 0);
      chk("dodge_hold", frames_left, 600);
      ticks(1);   chk("dodge_599", frames_left, 599);
      ticks(598); chk("dodge_1", frames_left, 1);
      chk("dodge_1_state", state, 1);
      ticks(1);
      chk("exp_state", state, 0);
      chk("exp_round", round, 1);
      chk("exp_frames", frames_left, 0);
      chk("exp_cursor", cursor, 0);

      // held unchanged 005A, then break sequence: no events
      for (int i = 0; i < 20; i++) cyc();
      chk("held_5a_state", state, 0);
      chk("held_5a_ehp", enemy_hp, 3);
      keycode = 16'hF05A;
      for (int i = 0; i < 20; i++) cyc();
      chk("break_state", state, 0);
      chk("break_ehp", enemy_hp, 3);

      // hp=0 with the final tick: GAMEOVER, no round credit
      keycode = 16'h005A;
      cyc();
      chk("fight2_state", state, 1);
      chk("fight2_ehp", enemy_hp, 2);
      ticks(599);
      chk("go_pre_frames", frames_left, 1);
      frame_tick = 1'b1; hp = 2'd0;
      cyc();
      frame_tick = 1'b0; hp = 2'd3;
      chk("go_state", state, 2);
      chk("go_round", round, 1);
      chk("go_frames", frames_left, 0);
      ticks(5); press(8'h74);
      chk("go_static_state", state, 2);
      chk("go_static_ehp", enemy_hp, 2);
      chk("go_static_cursor", cursor, 0);

      // restart from GAMEOVER
      press(8'h5A);
      chk("rs1_state", state, 0);
      chk("rs1_round", round, 0);
      chk("rs1_ehp", enemy_hp, 4);
      chk("rs1_pr", player_reset, 1);
      cyc();
      chk("rs1_pr_once", player_reset, 0);

      // MERCY with no acts -> dodge
      press(8'h74); press(8'h74);
      press(8'h5A);
      chk("mercy0_state", state, 1);
      chk("mercy0_ps", phase_start, 1);
      ticks(600);
      chk("mercy0_round", round, 1);
      for (int r = 0; r < 2; r++) begin
         press(8'h74); press(8'h5A);
         chk("act_state", state, 1);
         ticks(600);
         chk("act_back_menu", state, 0);
      end
      chk("act_round", round, 3);
      press(8'h74); press(8'h74); press(8'h5A);
      chk("mercy_win", state, 3);
      chk("mercy_win_frames", frames_left, 0);
      chk("mercy_win_ps", phase_start, 0);
      ticks(3);
      chk("win_static", state, 3);
      press(8'h5A);
      chk("rs2_state", state, 0);
      chk("rs2_ehp", enemy_hp, 4);
      chk("rs2_round", round, 0);
      chk("rs2_pr", player_reset, 1);
      cyc();
      chk("rs2_pr_once", player_reset, 0);

      // act counter cleared by restart: MERCY goes to dodge again
      press(8'h74); press(8'h74); press(8'h5A);
      chk("mercy_clr_state", state, 1);
      ticks(100);
      chk("mid_frames", frames_left, 500);
      keycode = 16'h0000;
      #3 btnC = 1'b1;
      #1;
      chk("async_state", state, 0);
      chk("async_frames", frames_left, 0);
      chk("async_round", round, 0);
      chk("async_ehp", enemy_hp, 4);
      cyc();
      btnC = 1'b0;
      cyc(); cyc();
      chk("post_rst_state", state, 0);
      chk("post_rst_round", round, 0);

      // four FIGHTs defeat the enemy
      for (int f = 0; f < 3; f++) begin
         press(8'h5A);
         chk("kill_dodge", state, 1);
         ticks(600);
      end
      chk("kill_ehp1", enemy_hp, 1);
      chk("kill_round", round, 3);
      press(8'h5A);
      chk("kill_win", state, 3);
      chk("kill_ehp0", enemy_hp, 0);
      chk("kill_frames", frames_left, 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL timeout: got running expected finished");
      $fatal(1);
   end

endmodule

// File: doc/game_state_manager.md
GAME_STATE_MANAGER -- requirements
Module: game_state_manager

Interface
REQ-001 Parameter DODGE_FRAMES, default 600, length of one dodge phase in frames (10 s at 60 Hz).
REQ-002 Parameter ENEMY_HP_INIT, default 4, enemy hit points at game start.
REQ-003 Parameter SPARE_ACTS, default 2, ACT selections required before MERCY succeeds.
REQ-004 clk  in  1  system clock; the block has one clock.
REQ-005 btnC  in  1  reset, asynchronous, active-high.
REQ-006 frame_tick  in  1  one-cycle pulse once per video frame.
REQ-007 keycode  in  16  PS/2 bytes from the keyboard block: [15:8] previous byte, [7:0] last byte.
REQ-008 hp  in  2  player HP from the player sprite.
REQ-009 state  out  2  game state: 00 MENU, 01 DODGE, 10 GAMEOVER, 11 WIN.
REQ-010 cursor  out  2  menu selection: 0 FIGHT, 1 ACT, 2 MERCY.
REQ-011 enemy_hp  out  3  remaining enemy HP.
REQ-012 frames_left  out  10  frames remaining in the current dodge phase.
REQ-013 round  out  8  number of completed dodge phases.
REQ-014 phase_start  out  1  one-cycle pulse on entry to DODGE, used to restart the bullets.
REQ-015 player_reset  out  1  one-cycle pulse on restart, used to restore player HP and position.

Function
REQ-016 Key event: a single-cycle internal pulse, generated when keycode differs from its value registered on the previous cycle, keycode[15:8]!=F0 and keycode[7:0]!=F0 (make codes only; break sequences are ignored).
REQ-017 Decoded keys (keycode[7:0] on a key event): 6B LEFT, 74 RIGHT, 5A ENTER; all other codes are ignored.
REQ-018 MENU, LEFT: cursor decrements, saturating at 0.
REQ-019 MENU, RIGHT: cursor increments, saturating at 2.
REQ-020 MENU, ENTER with cursor=0 (FIGHT): enemy_hp decrements by 1; if the result is 0, next state is WIN, otherwise DODGE.
REQ-021 MENU, ENTER with cursor=1 (ACT): the internal act counter increments, saturating at 7; next state is DODGE.
REQ-022 MENU, ENTER with cursor=2 (MERCY): if act counter >= SPARE_ACTS, next state is WIN; otherwise DODGE.
REQ-023 Entry to DODGE: frames_left loads DODGE_FRAMES and phase_start is high for exactly that transition cycle.
REQ-024 DODGE: each frame_tick decrements frames_left by 1; keys are ignored.
REQ-025 DODGE expiry: when frame_tick arrives with frames_left=1, frames_left goes to 0, round increments (wrapping at 255 -> 0), state goes to MENU and cursor resets to 0.
REQ-026 DODGE, hp=0 sampled on any cycle: next state is GAMEOVER.
REQ-027 Simultaneous hp=0 and expiry in the same cycle: GAMEOVER takes priority and round is not incremented.
REQ-028 GAMEOVER or WIN, ENTER: state goes to MENU and cursor, round, and act counter clear to 0.
REQ-029 Same restart transition: enemy_hp reloads ENEMY_HP_INIT and player_reset pulses for one cycle.
REQ-030 GAMEOVER and WIN hold all other outputs static.
REQ-031 frames_left is 0 in every state except DODGE.
REQ-032 All outputs are registered; a key event or expiry takes effect on the clock edge after the cycle it is detected.

Reset
REQ-033 btnC=1 immediately forces state=MENU, cursor=0, enemy_hp=ENEMY_HP_INIT, frames_left=0, round=0, act counter=0, phase_start=0, player_reset=0, and clears the registered keycode, regardless of clk.
REQ-034 Reset asserted mid-DODGE aborts the phase with no round increment; after release the block sits in MENU.

Verification
REQ-035 Reset, then RIGHT, RIGHT, RIGHT, LEFT -> cursor sequence 1, 2, 2, 1.
REQ-036 cursor=0, ENTER -> enemy_hp 4->3, state=01, phase_start pulses once, frames_left=600; 600 frame_ticks -> state=00, round=1.
REQ-037 In DODGE, drive hp=0 on the same cycle as the final frame_tick -> state=10, round unchanged.
REQ-038 In MENU, MERCY with 0 acts -> DODGE; after 2 ACT rounds, MERCY -> state=11; then ENTER -> state=00, enemy_hp=4, player_reset pulses once.
REQ-039 Hold keycode=F05A (break sequence), or a repeated unchanged 005A, for many cycles -> no key event, no state change.
REQ-040 Assert btnC between clock edges mid-DODGE -> outputs reach their reset values before the next edge.
